// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues PC requests on the instruction bus, stalls the
// PC while memory is slow, and delivers words to decode through registered IF/ID.
module inst_fetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  chip_enable,
   input  logic [ADDR_WIDTH-1:0] program_counter,
   input  logic [5:0]            stall,
   input  logic                  flush,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  stall_request,
   output logic [ADDR_WIDTH-1:0] id_pc,
   output logic [DATA_WIDTH-1:0] id_inst,
   output logic                  id_valid,
   output logic                  id_misaligned
);

   // state    | meaning
   // ST_IDLE  | chip_enable low, IF/ID holds NOP
   // ST_FETCH | request outstanding for program_counter
   // ST_HOLD  | word captured in hold buffer, decode stalled
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
   logic [DATA_WIDTH-1:0] id_inst_q, id_inst_d;
   logic                  id_valid_q, id_valid_d;
   logic                  id_mis_q, id_mis_d;
   logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
   logic [DATA_WIDTH-1:0] hold_inst_q, hold_inst_d;

   logic pc_aligned;
   logic hold_ifid;
   logic unused_stall;

   assign pc_aligned   = (program_counter[1:0] == 2'b00);
   assign hold_ifid    = stall[1];
   assign unused_stall = ^{stall[5:2], stall[0]};

   // Bus outputs depend only on state, flush, PC and ack -- never on stall.
   assign mem_addr      = program_counter;
   assign mem_req       = (state_q == ST_FETCH) && !flush && pc_aligned;
   assign stall_request = mem_req && !mem_ack;

   always_comb begin
      state_d     = state_q;
      id_pc_d     = id_pc_q;
      id_inst_d   = id_inst_q;
      id_valid_d  = id_valid_q;
      id_mis_d    = id_mis_q;
      hold_pc_d   = hold_pc_q;
      hold_inst_d = hold_inst_q;

      if (!chip_enable || flush) begin
         state_d     = chip_enable ? ST_FETCH : ST_IDLE;
         id_inst_d   = NOP_WORD;
         id_valid_d  = 1'b0;
         id_mis_d    = 1'b0;
         hold_pc_d   = '0;
         hold_inst_d = NOP_WORD;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_FETCH;
            end
            ST_FETCH: begin
               if (!pc_aligned) begin
                  if (!hold_ifid) begin
                     id_pc_d    = program_counter;
                     id_inst_d  = NOP_WORD;
                     id_valid_d = 1'b0;
                     id_mis_d   = 1'b1;
                  end
               end else if (mem_ack) begin
                  if (hold_ifid) begin
                     hold_pc_d   = program_counter;
                     hold_inst_d = mem_rdata;
                     state_d     = ST_HOLD;
                  end else begin
                     id_pc_d    = program_counter;
                     id_inst_d  = mem_rdata;
                     id_valid_d = 1'b1;
                     id_mis_d   = 1'b0;
                  end
               end else if (!hold_ifid) begin
                  id_inst_d  = NOP_WORD;
                  id_valid_d = 1'b0;
                  id_mis_d   = 1'b0;
               end
            end
            ST_HOLD: begin
               if (!hold_ifid) begin
                  id_pc_d    = hold_pc_q;
                  id_inst_d  = hold_inst_q;
                  id_valid_d = 1'b1;
                  id_mis_d   = 1'b0;
                  state_d    = ST_FETCH;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         id_pc_q     <= '0;
         id_inst_q   <= NOP_WORD;
         id_valid_q  <= 1'b0;
         id_mis_q    <= 1'b0;
         hold_pc_q   <= '0;
         hold_inst_q <= NOP_WORD;
      end else begin
         state_q     <= state_d;
         id_pc_q     <= id_pc_d;
         id_inst_q   <= id_inst_d;
         id_valid_q  <= id_valid_d;
         id_mis_q    <= id_mis_d;
         hold_pc_q   <= hold_pc_d;
         hold_inst_q <= hold_inst_d;
      end
   end

   assign id_pc         = id_pc_q;
   assign id_inst       = id_inst_q;
   assign id_valid      = id_valid_q;
   assign id_misaligned = id_mis_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios, then randomized traffic checked by a
// transaction-level scoreboard of words accepted from memory vs words consumed by decode.
module tb_inst_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic        chip_enable;
   logic [31:0] program_counter;
   logic [5:0]  stall;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall_request;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        id_misaligned;

   inst_fetch dut (
      .clock(clock), .reset(reset), .chip_enable(chip_enable),
      .program_counter(program_counter), .stall(stall), .flush(flush),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .stall_request(stall_request),
      .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
      .id_misaligned(id_misaligned)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t exp_q[$];
   int     checks = 0;
   int     failures = 0;
   int     consumed = 0;
   bit     sb_en = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0) return 32'h2401_0005;
      if (a == 32'd4) return 32'h2402_0007;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic ce, input logic [31:0] pc, input logic s1,
                        input logic fl, input logic ack, input logic [31:0] rd);
      chip_enable     = ce;
      program_counter = pc;
      stall           = {4'b0, s1, s1};
      flush           = fl;
      mem_ack         = ack;
      mem_rdata       = rd;
      #1;
   endtask

   // Decode consumes the IF/ID word in any cycle it is valid, not held and not flushed.
   always @(negedge clock) begin
      if (sb_en && id_valid && !stall[1] && !flush) begin
         entry_t e;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got pc=%h inst=%h expected none", id_pc, id_inst);
         end else begin
            e = exp_q.pop_front();
            consumed++;
            if (id_pc !== e.pc || id_inst !== e.inst) begin
               failures++;
               $display("FAIL sb_word: got pc=%h inst=%h expected pc=%h inst=%h",
                        id_pc, id_inst, e.pc, e.inst);
            end
         end
      end
   end

   // Random-phase memory and PC-register models.
   bit          mem_busy = 1'b0;
   int          mem_left = 0;
   logic [31:0] rpc;
   bit          prev_flush = 1'b0;
   bit          prev_stall0 = 1'b0;
   logic [31:0] flush_target;

   task automatic rand_cycle(input bit drain);
      logic s1, fl, ack;
      logic [31:0] rd;
      if (prev_flush) rpc = flush_target;
      else if (!prev_stall0) rpc = rpc + 32'd4;
      s1 = drain ? 1'b0 : ($urandom_range(0, 3) == 0);
      fl = drain ? 1'b0 : ($urandom_range(0, 19) == 0);
      flush_target = 32'($urandom_range(0, 255)) << 2;
      drive(1'b1, rpc, s1, fl, 1'b0, 32'h0);
      ack = 1'b0;
      rd  = $urandom;
      if (mem_req) begin
         if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_left = $urandom_range(0, 3);
         end
         if (mem_left == 0 && !drain) begin
            ack = 1'b1;
            mem_busy = 1'b0;
            rd = mem_word(rpc);
         end else if (mem_left > 0) begin
            mem_left--;
         end
      end else begin
         mem_busy = 1'b0;
         ack = drain ? 1'b0 : ($urandom_range(0, 9) == 0);
      end
      mem_ack   = ack;
      mem_rdata = rd;
      #1;
      chk("stall_request_rule", {31'b0, stall_request}, {31'b0, mem_req && !ack});
      chk("mem_addr_eq_pc", mem_addr, rpc);
      stall[0] = s1 | stall_request;
      prev_stall0 = stall[0];
      prev_flush  = fl;
      if (fl) exp_q.delete();
      else if (mem_req && ack) exp_q.push_back('{pc: rpc, inst: rd});
      tick();
   endtask

   initial begin
      int sreq_cycles;
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      tick();
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_stall_request", {31'b0, stall_request}, 32'd0);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_inst", id_inst, 32'd0);
      chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
      chk("rst_id_misaligned", {31'b0, id_misaligned}, 32'd0);
      reset = 1'b0;

      // Zero-wait memory, back-to-back at 0 and 4.
      drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("idle_no_req", {31'b0, mem_req}, 32'd0);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b1, mem_word(32'(i * 4)));
         chk("zw_mem_req", {31'b0, mem_req}, 32'd1);
         chk("zw_stall_request", {31'b0, stall_request}, 32'd0);
         tick();
         chk("zw_id_pc", id_pc, 32'(i * 4));
         chk("zw_id_inst", id_inst, mem_word(32'(i * 4)));
         chk("zw_id_valid", {31'b0, id_valid}, 32'd1);
      end

      // Three wait cycles at PC 8.
      sreq_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
         if (stall_request) sreq_cycles++;
         chk("wait_mem_addr", mem_addr, 32'd8);
         tick();
         chk("wait_id_valid", {31'b0, id_valid}, 32'd0);
      end
      drive(1'b1, 32'd8, 1'b0, 1'b0, 1'b1, mem_word(32'd8));
      if (stall_request) sreq_cycles++;
      chk("wait_sreq_cycles", 32'(sreq_cycles), 32'd3);
      tick();
      chk("wait_id_pc", id_pc, 32'd8);
      chk("wait_id_valid_ack", {31'b0, id_valid}, 32'd1);

      // Ack at PC 12 under stall[1] for two cycles.
      drive(1'b1, 32'd12, 1'b1, 1'b0, 1'b1, mem_word(32'd12));
      tick();
      drive(1'b1, 32'd12, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("hold_mem_req", {31'b0, mem_req}, 32'd0);
      tick();
      chk("hold_id_pc_kept", id_pc, 32'd8);
      chk("hold_id_inst_kept", id_inst, mem_word(32'd8));
      drive(1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("hold_rel_mem_req", {31'b0, mem_req}, 32'd0);
      chk("hold_rel_sreq", {31'b0, stall_request}, 32'd0);
      tick();
      chk("hold_out_pc", id_pc, 32'd12);
      chk("hold_out_inst", id_inst, mem_word(32'd12));
      chk("hold_out_valid", {31'b0, id_valid}, 32'd1);
      drive(1'b1, 32'd16, 1'b0, 1'b0, 1'b1, mem_word(32'd16));
      chk("resume_mem_req", {31'b0, mem_req}, 32'd1);
      tick();
      chk("resume_id_pc", id_pc, 32'd16);

      // Flush in the ack cycle.
      drive(1'b1, 32'd20, 1'b1, 1'b1, 1'b1, mem_word(32'd20));
      chk("flush_mem_req", {31'b0, mem_req}, 32'd0);
      tick();
      chk("flush_id_valid", {31'b0, id_valid}, 32'd0);
      chk("flush_id_inst", id_inst, 32'd0);
      drive(1'b1, 32'd20, 1'b0, 1'b0, 1'b1, mem_word(32'd20));
      tick();
      chk("post_flush_id_pc", id_pc, 32'd20);
      chk("post_flush_valid", {31'b0, id_valid}, 32'd1);

      // Misaligned PC.
      drive(1'b1, 32'd6, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
      chk("mis_mem_req", {31'b0, mem_req}, 32'd0);
      chk("mis_sreq", {31'b0, stall_request}, 32'd0);
      tick();
      chk("mis_flag", {31'b0, id_misaligned}, 32'd1);
      chk("mis_valid", {31'b0, id_valid}, 32'd0);
      chk("mis_id_pc", id_pc, 32'd6);
      chk("mis_id_inst", id_inst, 32'd0);

      // Reset while waiting, then a stray ack.
      drive(1'b1, 32'd24, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("prerst_sreq", {31'b0, stall_request}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1'b1, 32'd24, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
      chk("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mid_sreq", {31'b0, stall_request}, 32'd0);
      chk("rst_mid_id_pc", id_pc, 32'd0);
      chk("rst_mid_misaligned", {31'b0, id_misaligned}, 32'd0);
      tick();
      chk("stray_ack_valid", {31'b0, id_valid}, 32'd0);
      chk("stray_ack_inst", id_inst, 32'd0);

      // Randomized traffic against the scoreboard.
      rpc = 32'd28;
      prev_stall0 = 1'b1;
      prev_flush = 1'b0;
      sb_en = 1'b1;
      for (int i = 0; i < 2000; i++) rand_cycle(1'b0);
      for (int i = 0; i < 6; i++) rand_cycle(1'b1);
      sb_en = 1'b0;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      checks++;
      if (consumed < 100) begin
         failures++;
         $display("FAIL sb_progress: got %0d words consumed, expected at least 100", consumed);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
